fmdll_seq_ctrl: RTL and testbench
=================================

Name: fmdll_seq_ctrl

Overview:
- Registered sequencer for the FMDLL delay-line input mux.
- Generates the N/M cycle counters and the 2-bit mux select `Sel` each `clk_out` cycle.
- Owns run/stop control and a valid/ready handshake that loads new N/M ratios only at frame boundaries.
- Feeds the delay-line mux directly and replaces free-running counter glue.

Parameters:
- NW, 4, width of N ratio and `N_counter`
- MW, 2, width of M ratio and `M_counter`
- LOCK_CNT, 8, consecutive balanced frames required for `locked` (used only with the optional feature)

Ports:
- clk_out  in  1  block clock (DLL output clock), rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable
- cfg_valid  in  1  new ratio offered
- cfg_n  in  NW  new N ratio
- cfg_m  in  MW  new M ratio
- cfg_ready  out  1  ratio can be accepted this cycle
- pd_up  in  1  phase detector up; sampled at frame wrap
- pd_dn  in  1  phase detector down; sampled at frame wrap
- N_counter  out  NW  current N count, range 1..n_r
- M_counter  out  MW  current M count, range 1..m_r
- Sel  out  2  mux select: 00 = reference, 10 = recirculate, 01 = frame end
- frame_done  out  1  one-cycle pulse in the first cycle of a new frame
- busy  out  1  sequencer active (RUN or FINISH)
- locked  out  1  lock indication

Behaviour:
- Clock/reset: one clock, `clk_out`. Reset `rst` is asynchronous and active-high. All outputs are registered.
- Reset values: `N_counter`=1, `M_counter`=1, `Sel`=00, `frame_done`=0, `busy`=0, `locked`=0, state=IDLE, n_r=1, m_r=1.
- Ratio clamp: `cfg_n`=0 or `cfg_m`=0 is stored as 1. Counters never exceed n_r/m_r.
- States:
  - IDLE: counters held at (1,1), `Sel`=00, `cfg_ready`=1. en=1 → RUN; the first RUN cycle shows (1,1).
  - RUN: every cycle `N_counter`++. When N==n_r, N wraps to 1 and M++. When N==n_r and M==m_r, both wrap to 1 and `frame_done`=1 in the wrap cycle.
    - en=0 in RUN → FINISH.
  - FINISH: counts as RUN. At frame wrap → IDLE with counters (1,1). en=1 during FINISH → RUN with no interruption.
- `Sel` is registered alongside the counters and reflects the decode of the counter values shown in the same cycle. Priority order:
  1. M==1 → 00
  2. N==n_r and M!=m_r → 10
  3. N==n_r and M==m_r → 01
  4. otherwise hold the previous `Sel`
- `cfg_ready`:
  - 1 in IDLE.
  - In RUN/FINISH, 1 only in the last cycle of a frame (N==n_r, M==m_r).
  - Transfer occurs when `cfg_valid` and `cfg_ready` are both high at the clock edge. The new ratio governs the next cycle and frame.
  - `cfg_valid` may be held indefinitely without being accepted.
- `busy`=1 in RUN and FINISH.
- n_r=1: N stays 1 and M advances every cycle. n_r=m_r=1: `frame_done` is high continuously and `Sel`=00.
- `rst` mid-frame: all state returns to reset values immediately. No partial frame is completed.

Optional Feature:
- Macro: FMDLL_LOCK_DET_EN.
- With the macro, at each frame wrap:
  - pd_up==pd_dn → saturating lock counter increments toward LOCK_CNT.
  - Otherwise the counter clears.
  - `locked`=1 while the counter equals LOCK_CNT.
  - Counter and `locked` clear on cfg acceptance, on entry to IDLE, and on `rst`.
- Without the macro: `pd_up`/`pd_dn` are ignored and `locked` is tied to 0.

Test Plan:
- Reset: assert `rst` mid-RUN → same cycle `N_counter`=1, `M_counter`=1, `Sel`=00, `frame_done`=0, `busy`=0, `cfg_ready`=1.
- Load N=3, M=3 in IDLE, then en=1 → (N,M,Sel) per cycle: (1,1,00)(2,1,00)(3,1,00)(1,2,00)(2,2,00)(3,2,10)(1,3,10)(2,3,10)(3,3,01)(1,1,00) with `frame_done`=1.
- N=3, M=3 running; hold `cfg_valid` with 5,2 from (1,2) → `cfg_ready` low until (3,3). Accepted there. Next frame runs N to 5 and M to 2, then wraps.
- Drop en at (2,2) → counting continues to (3,3), then IDLE at (1,1) with `busy`=0. Re-raise en at (2,3) of a later frame → no stop.
- `cfg_n`=0, `cfg_m`=0 → clamped to 1,1. `frame_done` high every cycle, `Sel`=00, counters fixed at (1,1).
- FMDLL_LOCK_DET_EN: pd_up=pd_dn=0 for 8 frames → `locked`=1 after the 8th wrap. pd_up=1, pd_dn=0 at the next wrap → `locked`=0.

Source files
------------

// File: rtl/fmdll_seq_ctrl_if.sv
// fmdll_seq_ctrl_if: valid/ready channel carrying new N/M ratios into fmdll_seq_ctrl.
interface fmdll_seq_ctrl_if #(
    parameter int NW = 4,
    parameter int MW = 2
);
    logic          cfg_valid;
    logic [NW-1:0] cfg_n;
    logic [MW-1:0] cfg_m;
    logic          cfg_ready;
    modport master(output cfg_valid, cfg_n, cfg_m, input cfg_ready);
    modport slave(input cfg_valid, cfg_n, cfg_m, output cfg_ready);
endinterface

// File: rtl/fmdll_seq_ctrl.sv
// fmdll_seq_ctrl: N/M frame sequencer and delay-line mux select for the FMDLL.
// Define FMDLL_LOCK_DET_EN to enable the phase-detector lock counter.
module fmdll_seq_ctrl #(
    parameter int NW       = 4,
    parameter int MW       = 2,
    parameter int LOCK_CNT = 8
) (
    input  logic            clk_out,
    input  logic            rst,
    input  logic            en,
    input  logic            pd_up,
    input  logic            pd_dn,
    fmdll_seq_ctrl_if.slave cfg,
    output logic [NW-1:0]   N_counter,
    output logic [MW-1:0]   M_counter,
    output logic [1:0]      Sel,
    output logic            frame_done,
    output logic            busy,
    output logic            locked
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t        state, state_nx;
    logic [NW-1:0] n_r, n_nx, cnt_n_nx;
    logic [MW-1:0] m_r, m_nx, cnt_m_nx;
    logic [1:0]    sel_nx;
    logic          run, n_end, wrap, acc;

    // Everything is decoded from the values the next cycle will show, so Sel and
    // cfg_ready line up with the counters they describe.
    always_comb begin
        run      = state != IDLE;
        n_end    = N_counter == n_r;
        wrap     = run && n_end && M_counter == m_r;
        acc      = cfg.cfg_valid && cfg.cfg_ready;
        n_nx     = !acc ? n_r : cfg.cfg_n == '0 ? NW'(1) : cfg.cfg_n;
        m_nx     = !acc ? m_r : cfg.cfg_m == '0 ? MW'(1) : cfg.cfg_m;
        state_nx = !run ? (en ? RUN : IDLE) : en ? RUN : wrap ? IDLE : FINISH;
        cnt_n_nx = (!run || n_end) ? NW'(1) : N_counter + NW'(1);
        cnt_m_nx = (!run || wrap) ? MW'(1) : n_end ? M_counter + MW'(1) : M_counter;
        sel_nx   = cnt_m_nx == MW'(1) ? 2'b00 : cnt_n_nx != n_nx ? Sel :
                   cnt_m_nx == m_nx ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            n_r           <= NW'(1);
            m_r           <= MW'(1);
            N_counter     <= NW'(1);
            M_counter     <= MW'(1);
            Sel           <= 2'b00;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
            cfg.cfg_ready <= 1'b1;
        end else begin
            state         <= state_nx;
            n_r           <= n_nx;
            m_r           <= m_nx;
            N_counter     <= cnt_n_nx;
            M_counter     <= cnt_m_nx;
            Sel           <= sel_nx;
            frame_done    <= wrap;
            busy          <= state_nx != IDLE;
            cfg.cfg_ready <= state_nx == IDLE || (cnt_n_nx == n_nx && cnt_m_nx == m_nx);
        end
    end

`ifdef FMDLL_LOCK_DET_EN
    localparam int LW = $clog2(LOCK_CNT + 1);
    logic [LW-1:0] lock_cnt, lock_nx;

    always_comb
        lock_nx = (acc || state_nx == IDLE) ? '0 : !wrap ? lock_cnt :
                  pd_up != pd_dn ? '0 : lock_cnt == LW'(LOCK_CNT) ? lock_cnt : lock_cnt + LW'(1);

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            lock_cnt <= lock_nx;
            locked   <= lock_nx == LW'(LOCK_CNT);
        end
    end
`else
    logic unused_pd;
    assign unused_pd = pd_up ^ pd_dn ^ (LOCK_CNT == 0);
    assign locked    = 1'b0;
`endif
endmodule

// File: tb/tb_fmdll_seq_ctrl.sv
// tb_fmdll_seq_ctrl: scoreboard bench for fmdll_seq_ctrl; each step's expected
// {N,M,Sel,frame_done,busy,cfg_ready} is queued as its stimulus is driven.
module tb_fmdll_seq_ctrl;
    logic       clk_out = 1'b0;
    logic       rst, en, pd_up, pd_dn;
    logic [3:0] N_counter;
    logic [1:0] M_counter, Sel;
    logic       frame_done, busy, locked;
    int         n_chk = 0;
    int         n_fail = 0;

    fmdll_seq_ctrl_if #(.NW(4), .MW(2)) cfg();

    fmdll_seq_ctrl #(.NW(4), .MW(2), .LOCK_CNT(8)) dut (
        .clk_out(clk_out), .rst(rst), .en(en), .pd_up(pd_up), .pd_dn(pd_dn), .cfg(cfg),
        .N_counter(N_counter), .M_counter(M_counter), .Sel(Sel),
        .frame_done(frame_done), .busy(busy), .locked(locked)
    );

    always #5 clk_out = ~clk_out;

    typedef struct packed {
        logic        en;
        logic        vld;
        logic [3:0]  cn;
        logic [1:0]  cm;
        logic [10:0] exp;
    } step_t;

    step_t       sq[$];
    logic [10:0] exp_q[$];
    logic [10:0] obs;
    localparam logic [10:0] RST_VAL = 11'b0001_01_00_0_0_1;
    assign obs = {N_counter, M_counter, Sel, frame_done, busy, cfg.cfg_ready};

    function automatic step_t st(logic e, logic v, int cn, int cm, int n, int m,
                                 logic [1:0] s, logic fd, logic bz, logic rd);
        return '{e, v, 4'(cn), 2'(cm), {4'(n), 2'(m), s, fd, bz, rd}};
    endfunction

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; pd_up = 1'b0; pd_dn = 1'b0;
        cfg.cfg_valid = 1'b0; cfg.cfg_n = '0; cfg.cfg_m = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; pd_up = 1'b0; pd_dn = 1'b0;
        cfg.cfg_valid = 1'b0; cfg.cfg_n = '0; cfg.cfg_m = '0;
        #2;
        n_chk++;
        if (obs !== RST_VAL) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b (N|M|sel|fd|busy|rdy)", obs, RST_VAL);
        end
        n_chk++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_locked: got %b want 0", locked);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        step_t s; logic [10:0] e; int i = 0;
        do_reset();
        sq.push_back(st(0,1,3,3, 1,1,2'b00,0,0,1));
        sq.push_back(st(1,0,0,0, 1,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 2,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 3,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 1,2,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 2,2,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 3,2,2'b10,0,1,0));
        sq.push_back(st(1,0,0,0, 1,3,2'b10,0,1,0));
        sq.push_back(st(1,0,0,0, 2,3,2'b10,0,1,0));
        sq.push_back(st(1,0,0,0, 3,3,2'b01,0,1,1));
        sq.push_back(st(1,0,0,0, 1,1,2'b00,1,1,0));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            en = s.en; cfg.cfg_valid = s.vld; cfg.cfg_n = s.cn; cfg.cfg_m = s.cm;
            exp_q.push_back(s.exp);
            tick();
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL basic step %0d: got %b want %b (N|M|sel|fd|busy|rdy)", i, obs, e);
            end
            i++;
        end
    endtask

    task automatic test_hold();
        step_t s; logic [10:0] e; int i = 0;
        sq.push_back(st(1,0,0,0, 2,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 3,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 1,2,2'b00,0,1,0));
        sq.push_back(st(1,1,5,2, 2,2,2'b00,0,1,0));
        sq.push_back(st(1,1,5,2, 3,2,2'b10,0,1,0));
        sq.push_back(st(1,1,5,2, 1,3,2'b10,0,1,0));
        sq.push_back(st(1,1,5,2, 2,3,2'b10,0,1,0));
        sq.push_back(st(1,1,5,2, 3,3,2'b01,0,1,1));
        sq.push_back(st(1,1,5,2, 1,1,2'b00,1,1,0));
        sq.push_back(st(1,0,0,0, 2,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 3,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 4,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 5,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 1,2,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 2,2,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 3,2,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 4,2,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 5,2,2'b01,0,1,1));
        sq.push_back(st(1,0,0,0, 1,1,2'b00,1,1,0));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            en = s.en; cfg.cfg_valid = s.vld; cfg.cfg_n = s.cn; cfg.cfg_m = s.cm;
            exp_q.push_back(s.exp);
            tick();
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL hold step %0d: got %b want %b (N|M|sel|fd|busy|rdy)", i, obs, e);
            end
            i++;
        end
    endtask

    task automatic test_finish();
        step_t s; logic [10:0] e; int i = 0;
        do_reset();
        sq.push_back(st(0,1,3,3, 1,1,2'b00,0,0,1));
        sq.push_back(st(1,0,0,0, 1,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 2,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 3,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 1,2,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 2,2,2'b00,0,1,0));
        sq.push_back(st(0,0,0,0, 3,2,2'b10,0,1,0));
        sq.push_back(st(0,0,0,0, 1,3,2'b10,0,1,0));
        sq.push_back(st(0,0,0,0, 2,3,2'b10,0,1,0));
        sq.push_back(st(0,0,0,0, 3,3,2'b01,0,1,1));
        sq.push_back(st(0,0,0,0, 1,1,2'b00,1,0,1));
        sq.push_back(st(0,0,0,0, 1,1,2'b00,0,0,1));
        sq.push_back(st(1,0,0,0, 1,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 2,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 3,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 1,2,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 2,2,2'b00,0,1,0));
        sq.push_back(st(0,0,0,0, 3,2,2'b10,0,1,0));
        sq.push_back(st(0,0,0,0, 1,3,2'b10,0,1,0));
        sq.push_back(st(0,0,0,0, 2,3,2'b10,0,1,0));
        sq.push_back(st(1,0,0,0, 3,3,2'b01,0,1,1));
        sq.push_back(st(1,0,0,0, 1,1,2'b00,1,1,0));
        sq.push_back(st(1,0,0,0, 2,1,2'b00,0,1,0));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            en = s.en; cfg.cfg_valid = s.vld; cfg.cfg_n = s.cn; cfg.cfg_m = s.cm;
            exp_q.push_back(s.exp);
            tick();
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL finish step %0d: got %b want %b (N|M|sel|fd|busy|rdy)", i, obs, e);
            end
            i++;
        end
    endtask

    task automatic test_clamp();
        step_t s; logic [10:0] e; int i = 0;
        do_reset();
        sq.push_back(st(0,1,0,0, 1,1,2'b00,0,0,1));
        sq.push_back(st(1,0,0,0, 1,1,2'b00,0,1,1));
        sq.push_back(st(1,0,0,0, 1,1,2'b00,1,1,1));
        sq.push_back(st(1,0,0,0, 1,1,2'b00,1,1,1));
        sq.push_back(st(1,0,0,0, 1,1,2'b00,1,1,1));
        sq.push_back(st(1,1,0,3, 1,1,2'b00,1,1,0));
        sq.push_back(st(1,0,0,0, 1,2,2'b10,0,1,0));
        sq.push_back(st(1,0,0,0, 1,3,2'b01,0,1,1));
        sq.push_back(st(1,0,0,0, 1,1,2'b00,1,1,0));
        sq.push_back(st(1,0,0,0, 1,2,2'b10,0,1,0));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            en = s.en; cfg.cfg_valid = s.vld; cfg.cfg_n = s.cn; cfg.cfg_m = s.cm;
            exp_q.push_back(s.exp);
            tick();
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL clamp step %0d: got %b want %b (N|M|sel|fd|busy|rdy)", i, obs, e);
            end
            i++;
        end
    endtask

    task automatic test_reset_mid();
        step_t s; logic [10:0] e; int i = 0;
        do_reset();
        sq.push_back(st(0,1,3,3, 1,1,2'b00,0,0,1));
        sq.push_back(st(1,0,0,0, 1,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 2,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 3,1,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 1,2,2'b00,0,1,0));
        sq.push_back(st(1,0,0,0, 2,2,2'b00,0,1,0));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            en = s.en; cfg.cfg_valid = s.vld; cfg.cfg_n = s.cn; cfg.cfg_m = s.cm;
            exp_q.push_back(s.exp);
            tick();
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL midrst step %0d: got %b want %b (N|M|sel|fd|busy|rdy)", i, obs, e);
            end
            i++;
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (obs !== RST_VAL) begin
            n_fail++;
            $display("FAIL midrst_async: got %b want %b (N|M|sel|fd|busy|rdy)", obs, RST_VAL);
        end
        en = 1'b0;
        @(negedge clk_out) rst = 1'b0;
        tick();
        n_chk++;
        if (obs !== RST_VAL) begin
            n_fail++;
            $display("FAIL midrst_idle: got %b want %b (N|M|sel|fd|busy|rdy)", obs, RST_VAL);
        end
    endtask

    task automatic test_lock();
        logic exp_l;
        do_reset();
        cfg.cfg_valid = 1'b1; cfg.cfg_n = 4'd1; cfg.cfg_m = 2'd1;
        tick();
        cfg.cfg_valid = 1'b0; en = 1'b1;
        tick();
        for (int k = 1; k <= 9; k++) begin
            if (k == 9) pd_up = 1'b1;
            tick();
`ifdef FMDLL_LOCK_DET_EN
            exp_l = k == 8;
`else
            exp_l = 1'b0;
`endif
            n_chk++;
            if (locked !== exp_l) begin
                n_fail++;
                $display("FAIL lock wrap %0d: got locked=%b want %b", k, locked, exp_l);
            end
        end
        en = 1'b0; pd_up = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_finish();
        test_clamp();
        test_reset_mid();
        test_lock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
